key_sw_capture: RTL and testbench

KEY_SW_CAPTURE -- requirements
Module: key_sw_capture

---
 rtl/key_sw_capture.sv | 127 ++++++++++++
 tb/tb_key_sw_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_sw_capture.sv
// Push-button capture: synchronizes and debounces an active-low key, latches the
// switch vector on a qualified press and offers it downstream via valid/ready.
module key_sw_capture #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DW        = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key,
    input  logic [DW-1:0] sw,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic [7:0]    press_cnt
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DEB_PRESS = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] DEB_REL   = 2'd3;

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic          key_s1_q, key_s_q;
    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic          busy_q, busy_d;

    // Synchronizer idles high so reset looks like a released key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q <= 1'b1;
            key_s_q  <= 1'b1;
        end else begin
            key_s1_q <= key;
            key_s_q  <= key_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            IDLE: begin
                if (!key_s_q) begin
                    if (DB_CYCLES == 1) begin
                        data_d  = sw;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = DEB_PRESS;
                    end
                end
            end
            DEB_PRESS: begin
                if (key_s_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    data_d  = sw;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    pcnt_d  = pcnt_q + 8'd1;
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end
            end
            DEB_REL: begin
                // cnt holds the run of consecutive high samples seen so far
                if (!key_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            pcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pcnt_q  <= pcnt_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;
    assign press_cnt = pcnt_q;

endmodule

// File: tb/tb_key_sw_capture.sv
// Directed and randomized checks of key_sw_capture against a run-length based
// reference model of the press/hold/release behaviour.
module tb_key_sw_capture;

    localparam int DB = 4;
    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key;
    logic [DW-1:0] sw;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [7:0]    press_cnt;

    key_sw_capture #(.DB_CYCLES(DB), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .sw        (sw),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vhigh  = 0;

    // Model: key delayed two edges, then run lengths of low/high samples.
    logic          m_d1, m_d2;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [7:0]    m_cnt;
    logic          m_rel;
    int            m_lo, m_hi;

    task automatic model_reset();
        m_d1 = 1'b1; m_d2 = 1'b1;
        m_valid = 1'b0; m_data = '0; m_cnt = '0;
        m_rel = 1'b0; m_lo = 0; m_hi = 0;
    endtask

    function automatic logic m_busy();
        return m_valid || m_rel || (m_lo != 0);
    endfunction

    task automatic model_edge(input logic k, input logic [DW-1:0] s, input logic r);
        if (m_valid) begin
            if (r) begin
                m_valid = 1'b0;
                m_cnt   = m_cnt + 8'd1;
                m_rel   = 1'b1;
                m_hi    = 0;
            end
        end else if (m_rel) begin
            m_hi = m_d2 ? m_hi + 1 : 0;
            if (m_hi == DB) begin
                m_rel = 1'b0;
                m_hi  = 0;
            end
        end else begin
            m_lo = m_d2 ? 0 : m_lo + 1;
            if (m_lo == DB) begin
                m_valid = 1'b1;
                m_data  = s;
                m_lo    = 0;
            end
        end
        m_d2 = m_d1;
        m_d1 = k;
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (out_valid === m_valid) else begin
            errors++;
            $error("FAIL %s valid got %0b exp %0b", tag, out_valid, m_valid);
        end
        checks++;
        assert (out_data === m_data) else begin
            errors++;
            $error("FAIL %s data got %h exp %h", tag, out_data, m_data);
        end
        checks++;
        assert (busy === m_busy()) else begin
            errors++;
            $error("FAIL %s busy got %0b exp %0b", tag, busy, m_busy());
        end
        checks++;
        assert (press_cnt === m_cnt) else begin
            errors++;
            $error("FAIL %s press_cnt got %0d exp %0d", tag, press_cnt, m_cnt);
        end
    endtask

    task automatic tick(input logic k, input logic [DW-1:0] s, input logic r, input string tag);
        key = k; sw = s; out_ready = r;
        @(posedge clk);
        if (rst_n) model_edge(k, s, r);
        #1;
        if (out_valid === 1'b1) vhigh++;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    task automatic expect_val(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    initial begin
        int v0;
        logic [7:0] c0;
        logic kr;
        rst_n = 1'b0; key = 1'b1; sw = '0; out_ready = 1'b0;
        model_reset();
        #1 check_all("reset");
        tick(1'b0, 9'h1FF, 1'b1, "in_reset");
        tick(1'b0, 9'h1FF, 1'b1, "in_reset");
        model_reset();
        check_all("reset_hold");
        key = 1'b1;
        #2 rst_n = 1'b1;

        // Basic press with ready held high
        repeat (3) tick(1'b1, 9'h16A, 1'b1, "idle");
        v0 = vhigh;
        repeat (8) tick(1'b0, 9'h16A, 1'b1, "press");
        repeat (8) tick(1'b1, 9'h16A, 1'b1, "release");
        expect_val("basic_vcycles", vhigh - v0, 1);
        expect_val("basic_data", int'(out_data), 'h16A);
        expect_val("basic_cnt", int'(press_cnt), 1);
        expect_val("basic_busy", int'(busy), 0);

        // Glitch rejection
        v0 = vhigh;
        repeat (2) tick(1'b0, 9'h055, 1'b1, "glitch");
        repeat (6) tick(1'b1, 9'h055, 1'b1, "glitch_rel");
        expect_val("glitch_vcycles", vhigh - v0, 0);
        expect_val("glitch_cnt", int'(press_cnt), 1);
        expect_val("glitch_busy", int'(busy), 0);

        // Backpressure, then key held low after handshake
        for (int i = 0; i < 20 && !m_valid; i++) tick(1'b0, 9'h16A, 1'b0, "bp_press");
        expect_val("bp_rise", int'(out_valid), 1);
        repeat (10) tick(1'b0, 9'h0AD, 1'b0, "bp_hold");
        expect_val("bp_data", int'(out_data), 'h16A);
        expect_val("bp_valid", int'(out_valid), 1);
        tick(1'b0, 9'h0AD, 1'b1, "bp_hs");
        expect_val("bp_cnt", int'(press_cnt), 2);
        v0 = vhigh;
        repeat (20) tick(1'b0, 9'h0AD, 1'b1, "held_low");
        expect_val("held_vcycles", vhigh - v0, 0);
        expect_val("held_busy", int'(busy), 1);
        repeat (8) tick(1'b1, 9'h0AD, 1'b1, "held_rel");

        // Release bounce
        v0 = vhigh;
        c0 = press_cnt;
        repeat (7) tick(1'b0, 9'h123, 1'b1, "bn_press");
        begin
            logic [11:0] pat;
            pat = 12'b110100111011;
            for (int i = 11; i >= 0; i--) tick(pat[i], 9'h123, 1'b1, "bounce");
        end
        repeat (8) tick(1'b1, 9'h123, 1'b1, "bn_rel");
        expect_val("bounce_vcycles", vhigh - v0, 1);
        expect_val("bounce_cnt", int'(press_cnt - c0), 1);

        // Randomized run-length key, random ready and switches
        kr = 1'b1;
        for (int r = 0; r < 120; r++) begin
            int len;
            kr  = ~kr;
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++)
                tick(kr, DW'($urandom), ($urandom_range(0, 3) != 0), "random");
        end
        repeat (10) tick(1'b1, 9'h000, 1'b1, "rand_settle");

        // Wrap of press counter
        c0 = m_cnt;
        for (int p = 0; p < 256; p++) begin
            repeat (DB + 4) tick(1'b0, DW'(p), 1'b1, "wrap_press");
            repeat (DB + 3) tick(1'b1, DW'(p), 1'b1, "wrap_rel");
        end
        expect_val("wrap_cnt", int'(press_cnt), int'(c0));

        // Reset during HOLD, key kept low through and after reset
        for (int i = 0; i < 20 && !m_valid; i++) tick(1'b0, 9'h0F0, 1'b0, "rh_press");
        expect_val("rh_valid", int'(out_valid), 1);
        pulse_reset("rh_reset");
        for (int i = 0; i < 20 && !m_valid; i++) tick(1'b0, 9'h13C, 1'b0, "rh_repress");
        expect_val("rh_recap", int'(out_valid), 1);
        tick(1'b0, 9'h13C, 1'b1, "rh_hs");
        expect_val("rh_cnt", int'(press_cnt), 1);
        expect_val("rh_data", int'(out_data), 'h13C);
        repeat (8) tick(1'b1, 9'h000, 1'b1, "rh_rel");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
